// File: rtl/comparator_pkg.sv
// ============================================================================
// Module      : comparator_pkg
// Description : Shared types and constants for the bit-serial comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package comparator_pkg;

    localparam int CMP_N_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_comparator.sv
// ============================================================================
// Module      : serial_comparator
// Description : MSB-first bit-serial unsigned comparator with early exit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_comparator
    import comparator_pkg::*;
#(
    parameter int N = CMP_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         L,
    output logic         G,
    output logic         E
);

    localparam int C_CNT_W = $clog2(N);

    cmp_state_t         r_state;
    cmp_state_t         w_state_next;
    logic [N-1:0]       r_sa;
    logic [N-1:0]       r_sb;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_lt;
    logic               r_gt;
    logic               r_eq;
    logic               w_msb_diff;
    logic               w_cnt_zero;

    assign w_msb_diff = r_sa[N-1] ^ r_sb[N-1];
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (w_msb_diff || w_cnt_zero) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: operands shift toward the MSB so only bit N-1 is ever examined.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_cnt <= '0;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa  <= a;
                        r_sb  <= b;
                        r_cnt <= C_CNT_W'(N - 1);
                        r_lt  <= 1'b0;
                        r_gt  <= 1'b0;
                        r_eq  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_msb_diff) begin
                        r_gt <= r_sa[N-1];
                        r_lt <= ~r_sa[N-1];
                    end else if (w_cnt_zero) begin
                        r_eq <= 1'b1;
                    end else begin
                        r_sa  <= {r_sa[N-2:0], 1'b0};
                        r_sb  <= {r_sb[N-2:0], 1'b0};
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign L = r_lt;
    assign G = r_gt;
    assign E = r_eq;

endmodule

`default_nettype wire

// File: tb/tb_serial_comparator.sv
// ============================================================================
// Module      : tb_serial_comparator
// Description : Directed and back-to-back random checks of serial_comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, L8, G8, E8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        busy32, done32, L32, G32, E32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_comparator #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .L     (L8),
        .G     (G8),
        .E     (E8)
    );

    serial_comparator #(.N(32)) u_dut32 (
        .clk   (clk),
        .rst   (rst),
        .start (start32),
        .a     (a32),
        .b     (b32),
        .busy  (busy32),
        .done  (done32),
        .L     (L32),
        .G     (G32),
        .E     (E32)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] lge;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at #1 after an edge with the 8-bit DUT in IDLE.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] lge, input int lat, input string tag);
        int   cyc;
        logic scan_ok;
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check({tag, " busy after accept"}, busy8, 1'b1);
        check({tag, " cleared after accept"}, {L8, G8, E8}, 3'b000);
        cyc = 0;
        scan_ok = 1'b1;
        while (!done8 && cyc < 40) begin
            if ({L8, G8, E8} != 3'b000) scan_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " zero during scan"}, scan_ok, 1'b1);
        check({tag, " result LGE"}, {L8, G8, E8}, lge);
        @(posedge clk); #1;
        check({tag, " done single pulse"}, done8, 1'b0);
        check({tag, " idle busy"}, busy8, 1'b0);
        check({tag, " result held"}, {L8, G8, E8}, lge);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[9];
        logic        seen;
        logic [31:0] ca, cb, x;
        logic [2:0]  exp_lge;
        int          exp_lat, hi, cyc, mode;

        vecs[0] = '{a: 8'h80, b: 8'h00, lge: 3'b010, lat: 1};
        vecs[1] = '{a: 8'h01, b: 8'h03, lge: 3'b100, lat: 7};
        vecs[2] = '{a: 8'h00, b: 8'h01, lge: 3'b100, lat: 8};
        vecs[3] = '{a: 8'hFF, b: 8'hFE, lge: 3'b010, lat: 8};
        vecs[4] = '{a: 8'h7F, b: 8'h80, lge: 3'b100, lat: 1};
        vecs[5] = '{a: 8'h10, b: 8'h0F, lge: 3'b010, lat: 4};
        vecs[6] = '{a: 8'h00, b: 8'h00, lge: 3'b001, lat: 8};
        vecs[7] = '{a: 8'hC3, b: 8'hC7, lge: 3'b100, lat: 6};
        vecs[8] = '{a: 8'h5A, b: 8'h4B, lge: 3'b010, lat: 4};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy8, 1'b0);
        check("reset done", done8, 1'b0);
        check("reset LGE", {L8, G8, E8}, 3'b000);
        check("reset busy32", busy32, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].lge, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Equal result held through idle, then cleared by the next start
        run8(8'hA5, 8'hA5, 3'b001, 8, "eqA5");
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("eqA5 held in idle", {L8, G8, E8, busy8}, 4'b0010);
        run8(8'h01, 8'h03, 3'b100, 7, "after_hold");

        // Re-pulsed start with swapped operands during SCAN is ignored
        a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h00;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("restart ignored done", done8, 1'b1);
        check("restart ignored LGE", {L8, G8, E8}, 3'b100);
        @(posedge clk); #1;
        check("restart ignored idle", busy8, 1'b0);

        // Reset mid-SCAN aborts without a done pulse
        a8 = 8'h3C; b8 = 8'h3C; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= done8;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        seen |= done8;
        check("abort outputs", {busy8, done8, L8, G8, E8}, 5'b00000);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen |= done8;
        end
        check("abort no done", seen, 1'b0);
        run8(8'h10, 8'h0F, 3'b010, 4, "post_abort");

        // N=32: start held high, 1000 back-to-back operations
        ca = $urandom; cb = $urandom;
        a32 = ca; b32 = cb; start32 = 1'b1;
        for (int op = 0; op < 1000; op++) begin
            @(posedge clk); #1;
            x = ca ^ cb;
            hi = -1;
            for (int k = 0; k < 32; k++) if (x[k]) hi = k;
            exp_lat = (hi < 0) ? 32 : 32 - hi;
            exp_lge = {ca < cb, ca > cb, ca == cb};
            mode = $urandom_range(0, 3);
            ca = $urandom;
            if (mode == 1)      cb = ca;
            else if (mode == 2) cb = ca ^ (32'h1 << $urandom_range(0, 31));
            else                cb = $urandom;
            a32 = ca; b32 = cb;
            cyc = 0;
            while (!done32 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            check($sformatf("b2b op%0d latency", op), cyc, exp_lat);
            check($sformatf("b2b op%0d LGE", op), {L32, G32, E32}, exp_lge);
            @(posedge clk); #1;
            check($sformatf("b2b op%0d idle", op), {busy32, done32}, 2'b00);
        end
        start32 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter N, default 32: operand width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a comparison; sampled only in IDLE.
REQ-005 a  input  N  operand A, unsigned; captured on the accepting edge.
REQ-006 b  input  N  operand B, unsigned; captured on the accepting edge.
REQ-007 busy  output  1  high in SCAN and DONE; low in IDLE.
REQ-008 done  output  1  single-cycle pulse marking valid result.
REQ-009 L  output  1  result a<b; registered, held until next accepted start.
REQ-010 G  output  1  result a>b; registered, held until next accepted start.
REQ-011 E  output  1  result a==b; registered, held until next accepted start.

Function
REQ-012 FSM states IDLE, SCAN, DONE; encoding from the shared package.
REQ-013 IDLE with start=1 at edge E0: capture a and b into shift registers, load bit counter with N-1, clear L/G/E to 0, go to SCAN.
REQ-014 IDLE with start=0: no state change; L/G/E hold their values.
REQ-015 SCAN: compare current MSBs of both shift registers, one bit per cycle, MSB first.
REQ-016 SCAN with MSBs different: set G=1 if A bit is 1, else L=1; go to DONE (early termination).
REQ-017 SCAN with MSBs equal and counter nonzero: shift both registers left by 1, decrement counter, stay in SCAN.
REQ-018 SCAN with MSBs equal and counter zero: set E=1; go to DONE.
REQ-019 Latency: with i = highest differing bit index, done is high in the cycle after edge E(N-i). With equal operands, done is high in the cycle after edge E(N).
REQ-020 DONE: done=1 for exactly one cycle; unconditional return to IDLE on the next edge.
REQ-021 start is ignored in SCAN and DONE; a and b are ignored except on the accepting edge.
REQ-022 Exactly one of L/G/E is 1 from the DONE cycle until the next accepted start; all three are 0 during SCAN.
REQ-023 Back-to-back: start held high continuously is accepted on the first IDLE edge after each DONE.

Reset
REQ-024 rst=1 at any edge forces IDLE, busy=0, done=0, L=0, G=0, E=0, counter=0, shift registers=0.
REQ-025 rst takes priority over start and all FSM transitions.
REQ-026 rst asserted mid-SCAN aborts the operation; no done pulse is produced for it.
REQ-027 The first start after rst deasserts is accepted normally.

Structure
REQ-028 Package comparator_pkg holds the FSM state typedef (IDLE/SCAN/DONE) and the default width constant CMP_N_DEFAULT=32.
REQ-029 Counter width is $clog2(N) bits, derived inside the module.
REQ-030 No sub-module is instantiated. The FSM, shift registers and counter live in one module.

Verification
REQ-031 N=8, a=0x80, b=0x00, start pulse -> done in the cycle after E1; G=1, L=0, E=0; busy low the following cycle.
REQ-032 N=8, a=0x01, b=0x03 -> bit 1 differs; done in the cycle after E7; L=1, G=0, E=0.
REQ-033 N=8, a=b=0xA5 -> done in the cycle after E8; E=1; result held in IDLE until the next start, then cleared.
REQ-034 N=8, a=0x00, b=0xFF, start re-pulsed during SCAN with a=0xFF, b=0x00 -> second start ignored; L=1 after E1.
REQ-035 N=8, a=b=0x3C, rst asserted after E4 -> IDLE next cycle, all outputs 0, no done pulse; a new start with a=0x10, b=0x0F -> G=1 after E4.
REQ-036 N=32, random operands with start held high for 1000 back-to-back operations -> each result matches the unsigned compare; each latency matches REQ-019.
